// File: rtl/adder_slice_seq.sv
`default_nettype none
// =============================================================================
// Module   : adder_slice_seq
// Purpose  : WIDTH-bit adder built from one shared SLICE-bit ripple slice used
//            once per cycle; two round-robin requesters, valid/ready on both
//            sides. Optional ADDSEQ_SAT_EN saturates the sum on carry-out.
// Revision : 1.0 - initial release
// =============================================================================
module adder_slice_seq #(
   parameter int WIDTH = 12,
   parameter int SLICE = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_cin,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_cin,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_cout,
   output logic             res_id
);

   localparam int NSL  = WIDTH / SLICE;
   localparam int IDXW = (NSL > 1) ? $clog2(NSL) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSL - 1);

   generate
      if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_width_check
         $error("adder_slice_seq: WIDTH must be a non-zero multiple of SLICE");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             rr_q, rr_d;
   logic             id_q, id_d;
   logic             carry_q, carry_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;

   logic             any_valid;
   logic             grant_id;
   logic             accept;
   logic [SLICE-1:0] a_sl;
   logic [SLICE-1:0] b_sl;
   logic [SLICE:0]   slice_res;

   // Ready is gated by rst so neither requester sees a handshake while reset is held.
   always_comb begin
      any_valid  = req0_valid | req1_valid;
      grant_id   = (req0_valid & req1_valid) ? rr_q : req1_valid;
      req0_ready = ~rst & (state_q == IDLE) & any_valid & ~grant_id;
      req1_ready = ~rst & (state_q == IDLE) & any_valid &  grant_id;
      accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
      a_sl       = a_q[idx_q * SLICE +: SLICE];
      b_sl       = b_q[idx_q * SLICE +: SLICE];
      slice_res  = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      id_d    = id_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               a_d     = grant_id ? req1_a   : req0_a;
               b_d     = grant_id ? req1_b   : req0_b;
               carry_d = grant_id ? req1_cin : req0_cin;
               id_d    = grant_id;
               rr_d    = ~grant_id;
               idx_d   = '0;
               sum_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[idx_q * SLICE +: SLICE] = slice_res[SLICE-1:0];
            carry_d = slice_res[SLICE];
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = DONE;
`ifdef ADDSEQ_SAT_EN
               if (slice_res[SLICE]) begin
                  sum_d = '1;
               end
`endif
            end
         end
         DONE: begin
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q    <= 1'b0;
         id_q    <= 1'b0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         id_q    <= id_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
      end
   end

   // Result fields are masked outside DONE so partial sums never reach the consumer.
   always_comb begin
      res_valid = (state_q == DONE);
      res_sum   = res_valid ? sum_q : '0;
      res_cout  = res_valid & carry_q;
      res_id    = res_valid & id_q;
   end

endmodule
`default_nettype wire
